prbs_checker: RTL and testbench
===============================

// Module: prbs_checker
// PURPOSE
//  Receive-side partner of the prbs generator: takes the N-bit PRBS word stream, self-synchronises a local LFSR to it,
//  then checks every later word against the prediction. Reports lock status, per-word error pulses and saturating
//  word/error counters. Sits at the far end of a link or loopback carrying the generator output.
// PARAMETERS
//  N          14       word/LFSR width; must equal the generator's N
//  TAPS       14'h2015 feedback mask (bit i set = state[i] in XOR); default x^14+x^5+x^3+x^1+1
//  LOCK_CNT   4        consecutive matching words in VERIFY required to declare lock (>=1)
//  UNLOCK_CNT 8        consecutive mismatching words in LOCKED that drop lock (>=1)
//  CNT_W      32       width of word_count and err_count
// PORTS
//  clk         in   1      single clock, all logic on posedge
//  rst         in   1      synchronous, active-high reset
//  in_valid    in   1      in_data holds a new PRBS word this cycle
//  in_data     in   N      received word (generator's rnd)
//  clr_counts  in   1      synchronous clear of word_count/err_count
//  locked      out  1      checker synchronised to stream
//  err_pulse   out  1      1-cycle pulse: previous valid word mismatched while LOCKED
//  err_count   out  CNT_W  saturating count of mismatched words while LOCKED
//  word_count  out  CNT_W  saturating count of valid words checked while LOCKED
// BEHAVIOUR
//  next(s) = {s[N-2:0], ^(s & TAPS)}; generator and checker use the same function.
//  Reset: state=SEARCH; expected=0; locked=0, err_pulse=0, err_count=0, word_count=0, run counters=0.
//  Cycles with in_valid=0: no state, counter or expected change; err_pulse=0.
//  FSM (all transitions evaluated only on in_valid=1):
//   SEARCH: in_data==0 -> ignored (LFSR lock-up value); else expected<=next(in_data), match_run<=0, go VERIFY.
//   VERIFY: in_data==expected -> expected<=next(expected), match_run++; at LOCK_CNT matches -> LOCKED.
//           mismatch -> reseed exactly as SEARCH from this word (all-zero word -> SEARCH); no error counted.
//   LOCKED: expected<=next(expected) always (no reseed). Match -> miss_run<=0. Mismatch -> err_pulse, err_count++,
//           miss_run++; at UNLOCK_CNT consecutive misses -> SEARCH, locked<=0. word_count++ on every valid word.
//  locked is registered: =1 the cycle after the LOCK_CNT-th matching word is sampled; =0 the cycle after the
//   UNLOCK_CNT-th miss. err_pulse latency: 1 cycle after the offending word is sampled.
//  Counters saturate at 2^CNT_W-1, never wrap. clr_counts wins over a simultaneous increment (result 0);
//   clr_counts does not affect FSM, lock or run counters.
//  rst at any time, mid-VERIFY or LOCKED included, returns to reset values next cycle; rst wins over everything.
//  Compare is full-word equality; a single flipped bit counts as one word error.
// STRUCTURE
//  prbs_pkg: default N/TAPS localparams, function prbs_next(state, taps), typedef enum {SEARCH,VERIFY,LOCKED}
//   chk_state_t; the generator is to import the same prbs_next.
//  One sub-module: sat_counter (CNT_W, inc, clr -> q), instanced for err_count and word_count.
//  FSM, expected register, match_run/miss_run counters stay in prbs_checker.
// TESTING
//  1 rst=1 for 2 cycles -> locked=0, err_pulse=0, err_count=0, word_count=0.
//  2 clean stream seeded 14'h0001 (0x0001,0x0003,0x0007,...), in_valid=1 -> locked rises cycle after 5th word, err_count=0.
//  3 locked; flip bit 0 of one word -> single err_pulse next cycle, err_count=1, locked stays 1, later words match.
//  4 locked; drive 8 words of 14'h0000 -> err_count=8, locked=0 after 8th; resume clean stream -> relock after 5 words.
//  5 in_valid low 3 cycles mid-stream, then continue sequence -> no err_pulse, word_count excludes idle cycles.
//  6 CNT_W=4, 20 injected errors (UNLOCK_CNT=32) -> err_count=15; clr_counts with same-cycle error -> err_count=0.
//  7 rst pulsed while in VERIFY after 2 matches -> SEARCH; relock needs full 1+LOCK_CNT words.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared PRBS definitions used by both the generator and the checker.
// Holds the default word width and tap mask, the LFSR step function and
// the checker state encoding.
package prbs_pkg;

  localparam int              PRBS_N     = 14;
  localparam logic [PRBS_N-1:0] PRBS_TAPS = 14'h2015;
  localparam int              PRBS_MAX_W = 64;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } chk_state_t;

  // One LFSR step on a word of the given width.
  // The new bit is the XOR of the tapped state bits, shifted in at bit 0.
  // Operands are carried at PRBS_MAX_W bits and masked down to width.
  function automatic logic [PRBS_MAX_W-1:0] prbs_next(
    input logic [PRBS_MAX_W-1:0] state,
    input logic [PRBS_MAX_W-1:0] taps,
    input int                    width
  );
    logic [PRBS_MAX_W-1:0] mask;
    logic                  fb;
    if (width >= PRBS_MAX_W)
      mask = '1;
    else
      mask = (PRBS_MAX_W'(1) << width) - PRBS_MAX_W'(1);
    fb = ^(state & taps & mask);
    prbs_next = ((state << 1) | PRBS_MAX_W'(fb)) & mask;
  endfunction

endpackage

// File: rtl/prbs_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over a simultaneous increment; the count sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  // Count up on inc, hold at the maximum value, zero on clr or rst
  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (inc && (q != '1))
      q <= q + CNT_W'(1);
  end

endmodule

// File: rtl/prbs_checker.sv
// PRBS receive checker.
// Seeds a local LFSR from the incoming word stream, confirms the seed over a
// run of matching words, then predicts and compares every later word while
// locked. Reports lock, a one-cycle error pulse and saturating counters.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int           N          = PRBS_N,
  parameter logic [N-1:0] TAPS       = PRBS_TAPS,
  parameter int           LOCK_CNT   = 4,
  parameter int           UNLOCK_CNT = 8,
  parameter int           CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [N-1:0]     in_data,
  input  logic             clr_counts,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(UNLOCK_CNT + 1);

  chk_state_t         state, state_next;
  logic [N-1:0]       expected, expected_next;
  logic [MATCH_W-1:0] match_run, match_run_next;
  logic [MISS_W-1:0]  miss_run, miss_run_next;
  logic               err_next;
  logic               err_inc;
  logic               word_inc;

  logic               is_match;
  logic               is_zero;
  logic [N-1:0]       seed_next;
  logic [N-1:0]       step_next;

  function automatic logic [N-1:0] next_word(input logic [N-1:0] s);
    next_word = N'(prbs_next(PRBS_MAX_W'(s), PRBS_MAX_W'(TAPS), N));
  endfunction

  assign is_match  = (in_data == expected);
  assign is_zero   = (in_data == '0);
  assign seed_next = next_word(in_data);
  assign step_next = next_word(expected);
  assign locked    = (state == LOCKED);

  // Next-state, prediction and run-counter logic; only valid words move anything
  always_comb begin
    state_next     = state;
    expected_next  = expected;
    match_run_next = match_run;
    miss_run_next  = miss_run;
    err_next       = 1'b0;
    err_inc        = 1'b0;
    word_inc       = 1'b0;

    if (in_valid) begin
      case (state)
        SEARCH: begin
          if (!is_zero) begin
            expected_next  = seed_next;
            match_run_next = '0;
            state_next     = VERIFY;
          end
        end

        VERIFY: begin
          if (is_match) begin
            expected_next = step_next;
            if (match_run == MATCH_W'(LOCK_CNT - 1)) begin
              match_run_next = '0;
              miss_run_next  = '0;
              state_next     = LOCKED;
            end else begin
              match_run_next = match_run + MATCH_W'(1);
            end
          end else if (!is_zero) begin
            expected_next  = seed_next;
            match_run_next = '0;
          end else begin
            match_run_next = '0;
            state_next     = SEARCH;
          end
        end

        LOCKED: begin
          expected_next = step_next;
          word_inc      = 1'b1;
          if (is_match) begin
            miss_run_next = '0;
          end else begin
            err_next = 1'b1;
            err_inc  = 1'b1;
            if (miss_run == MISS_W'(UNLOCK_CNT - 1)) begin
              miss_run_next = '0;
              state_next    = SEARCH;
            end else begin
              miss_run_next = miss_run + MISS_W'(1);
            end
          end
        end

        default: begin
          state_next = SEARCH;
        end
      endcase
    end
  end

  // State, prediction, run counters and the registered error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEARCH;
      expected  <= '0;
      match_run <= '0;
      miss_run  <= '0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_next;
      expected  <= expected_next;
      match_run <= match_run_next;
      miss_run  <= miss_run_next;
      err_pulse <= err_next;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_err_count (
    .clk (clk),
    .rst (rst),
    .inc (err_inc),
    .clr (clr_counts),
    .q   (err_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_word_count (
    .clk (clk),
    .rst (rst),
    .inc (word_inc),
    .clr (clr_counts),
    .q   (word_count)
  );

endmodule

// File: tb/tb_prbs_checker.sv
// Testbench for prbs_checker.
// Drives a default instance and a narrow-counter, slow-unlock instance with
// the same stream; a queue-based scoreboard compares every cycle against a
// behavioural model, plus directed checks at the notable points.
module tb_prbs_checker;

  localparam int LOCK_N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [13:0] in_data = '0;
  logic        clr_counts = 1'b0;

  logic        locked_a, err_pulse_a;
  logic [31:0] err_count_a, word_count_a;
  logic        locked_s, err_pulse_s;
  logic [3:0]  err_count_s, word_count_s;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        locked_a;
    logic        pulse_a;
    logic [31:0] errs_a;
    logic [31:0] words_a;
    logic        locked_s;
    logic        pulse_s;
    logic [3:0]  errs_s;
    logic [3:0]  words_s;
  } exp_t;

  exp_t exp_q[$];

  bit          m_locked[2];
  int          m_chain[2];
  logic [13:0] m_last[2];
  logic [13:0] m_pred[2];
  int          m_miss[2];
  longint      m_errs[2];
  longint      m_words[2];
  bit          m_pulse[2];

  logic [13:0] g;

  prbs_checker dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .clr_counts (clr_counts),
    .locked     (locked_a),
    .err_pulse  (err_pulse_a),
    .err_count  (err_count_a),
    .word_count (word_count_a)
  );

  prbs_checker #(.CNT_W(4), .UNLOCK_CNT(32)) dut_small (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .clr_counts (clr_counts),
    .locked     (locked_s),
    .err_pulse  (err_pulse_s),
    .err_count  (err_count_s),
    .word_count (word_count_s)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Reference LFSR step: next word is old word doubled plus the tap parity, modulo 2^14
  function automatic logic [13:0] ref_next(input logic [13:0] s);
    int ones;
    int v;
    ones = $countones(s & 14'h2015);
    v = int'(s) * 2 + (ones % 2);
    return 14'(v % 16384);
  endfunction

  task automatic checkOutput(input string name, input longint unsigned act, input longint unsigned expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Behavioural model: unlocked, track the length of the current self-consistent
  // run of words; lock once it spans LOCK_N+1 words. Locked, free-run the prediction.
  task automatic modelStep(input int k, input bit r, input bit v, input logic [13:0] d, input bit c);
    int     unlock_n;
    longint maxv;
    unlock_n = (k == 0) ? 8 : 32;
    maxv     = (k == 0) ? 64'hFFFF_FFFF : 15;
    if (r) begin
      m_locked[k] = 0; m_chain[k] = 0; m_last[k] = '0; m_pred[k] = '0;
      m_miss[k] = 0; m_errs[k] = 0; m_words[k] = 0; m_pulse[k] = 0;
      return;
    end
    m_pulse[k] = 0;
    if (v) begin
      if (!m_locked[k]) begin
        if (m_chain[k] > 0 && d == ref_next(m_last[k])) begin
          m_chain[k]++;
          m_last[k] = d;
        end else if (d != 0) begin
          m_chain[k] = 1;
          m_last[k] = d;
        end else begin
          m_chain[k] = 0;
        end
        if (m_chain[k] == LOCK_N + 1) begin
          m_locked[k] = 1;
          m_pred[k] = ref_next(d);
          m_miss[k] = 0;
        end
      end else begin
        if (m_words[k] < maxv) m_words[k]++;
        if (d != m_pred[k]) begin
          m_pulse[k] = 1;
          if (m_errs[k] < maxv) m_errs[k]++;
          m_miss[k]++;
          if (m_miss[k] == unlock_n) begin
            m_locked[k] = 0;
            m_chain[k] = 0;
          end
        end else begin
          m_miss[k] = 0;
        end
        m_pred[k] = ref_next(m_pred[k]);
      end
    end
    if (c) begin
      m_errs[k] = 0;
      m_words[k] = 0;
    end
  endtask

  task automatic applyStimulus(input bit r, input bit v, input logic [13:0] d, input bit c);
    exp_t e;
    @(negedge clk);
    rst = r;
    in_valid = v;
    in_data = d;
    clr_counts = c;
    modelStep(0, r, v, d, c);
    modelStep(1, r, v, d, c);
    e.locked_a = m_locked[0];
    e.pulse_a  = m_pulse[0];
    e.errs_a   = 32'(m_errs[0]);
    e.words_a  = 32'(m_words[0]);
    e.locked_s = m_locked[1];
    e.pulse_s  = m_pulse[1];
    e.errs_s   = 4'(m_errs[1]);
    e.words_s  = 4'(m_words[1]);
    exp_q.push_back(e);
  endtask

  task automatic sendClean();
    applyStimulus(1'b0, 1'b1, g, 1'b0);
    g = ref_next(g);
  endtask

  task automatic sendWord(input logic [13:0] d);
    applyStimulus(1'b0, 1'b1, d, 1'b0);
    g = ref_next(g);
  endtask

  task automatic sendIdle();
    applyStimulus(1'b0, 1'b0, 14'($urandom), 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard monitor: one expectation per driven cycle, compared just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("sb_locked_a", locked_a, e.locked_a);
        checkOutput("sb_pulse_a", err_pulse_a, e.pulse_a);
        checkOutput("sb_errs_a", err_count_a, e.errs_a);
        checkOutput("sb_words_a", word_count_a, e.words_a);
        checkOutput("sb_locked_s", locked_s, e.locked_s);
        checkOutput("sb_pulse_s", err_pulse_s, e.pulse_s);
        checkOutput("sb_errs_s", err_count_s, e.errs_s);
        checkOutput("sb_words_s", word_count_s, e.words_s);
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  // Main stimulus sequence
  initial begin
    int r;
    g = 14'h0001;

    // reset held two cycles
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    settle();
    checkOutput("rst_locked", locked_a, 0);
    checkOutput("rst_pulse", err_pulse_a, 0);
    checkOutput("rst_errs", err_count_a, 0);
    checkOutput("rst_words", word_count_a, 0);

    // clean stream seeded with 1: lock after the fifth word
    checkOutput("seed_first", g, 14'h0001);
    repeat (4) sendClean();
    settle();
    checkOutput("lock_early", locked_a, 0);
    sendClean();
    settle();
    checkOutput("lock_fifth", locked_a, 1);
    checkOutput("lock_errs", err_count_a, 0);
    repeat (10) sendClean();

    // single flipped bit while locked
    sendWord(g ^ 14'h0001);
    settle();
    checkOutput("flip_pulse", err_pulse_a, 1);
    checkOutput("flip_errs", err_count_a, 1);
    checkOutput("flip_locked", locked_a, 1);
    repeat (6) sendClean();
    settle();
    checkOutput("flip_after_errs", err_count_a, 1);
    checkOutput("flip_after_pulse", err_pulse_a, 0);

    // eight all-zero words drop lock, clean stream relocks after five
    repeat (8) sendWord(14'h0000);
    settle();
    checkOutput("zero_unlock", locked_a, 0);
    checkOutput("zero_errs", err_count_a, 9);
    checkOutput("zero_small_locked", locked_s, 1);
    repeat (4) sendClean();
    settle();
    checkOutput("relock_early", locked_a, 0);
    sendClean();
    settle();
    checkOutput("relock", locked_a, 1);

    // idle gap mid-stream
    repeat (3) sendClean();
    repeat (3) sendIdle();
    repeat (5) sendClean();
    settle();
    checkOutput("idle_pulse", err_pulse_a, 0);
    checkOutput("idle_errs", err_count_a, 9);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 15)
        sendIdle();
      else if (r < 23)
        sendWord(g ^ 14'(1 << $urandom_range(0, 13)));
      else if (r < 25)
        sendWord(14'h0000);
      else if (r < 27)
        sendWord(14'($urandom));
      else if (r < 29) begin
        applyStimulus(1'b0, 1'b1, g, 1'b1);
        g = ref_next(g);
      end else if (r < 30)
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
      else
        sendClean();
    end

    // known-locked starting point for saturation test
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    repeat (12) sendClean();
    applyStimulus(1'b0, 1'b1, g, 1'b1);
    g = ref_next(g);
    for (int i = 0; i < 20; i++) begin
      sendWord(g ^ 14'(1 << $urandom_range(0, 13)));
      sendClean();
    end
    settle();
    checkOutput("sat_small_errs", err_count_s, 15);
    checkOutput("sat_main_errs", err_count_a, 20);
    checkOutput("sat_small_locked", locked_s, 1);
    applyStimulus(1'b0, 1'b1, g ^ 14'h0001, 1'b1);
    g = ref_next(g);
    settle();
    checkOutput("clr_wins_small", err_count_s, 0);
    checkOutput("clr_wins_main", err_count_a, 0);
    checkOutput("clr_pulse", err_pulse_a, 1);

    // reset mid-VERIFY: full relock sequence needed afterwards
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    repeat (3) sendClean();
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    repeat (4) sendClean();
    settle();
    checkOutput("verify_rst_early", locked_a, 0);
    sendClean();
    settle();
    checkOutput("verify_rst_lock", locked_a, 1);

    repeat (3) sendIdle();
    repeat (2) @(posedge clk);
    #3;
    checkOutput("sb_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
